// File: rtl/mac_pe_param.sv
// Weight-stationary systolic MAC processing element with double-buffered weight, pass-through or local-accumulate sum.
// Latency: a_in to a_out 1 cycle, a_in/a_vld_in to psum_out/psum_vld 2 cycles, one sample accepted per cycle.
// Backpressure: none; the pipeline never stalls and the consumer must take every psum_vld. MAC_PE_SAT_EN enables saturation and ovf.
module mac_pe_param #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              mode,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] w_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_vld,
    output logic              ovf
);

    logic [DATA_W-1:0]   shadow_w;
    logic [DATA_W-1:0]   active_w;

    logic [2*DATA_W-1:0] s1_prod;
    logic [ACC_W-1:0]    s1_psum;
    logic                s1_mode;
    logic                s1_vld;

    logic [ACC_W-1:0]    acc;

    logic [2*DATA_W-1:0]        prod_u;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [DATA_W-1:0]   a_sgn;
    logic signed [DATA_W-1:0]   w_sgn;
    logic signed [2*DATA_W-1:0] s1_prod_sgn;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           addend;
    logic [ACC_W-1:0]           sum_res;

    assign w_out = shadow_w;

    // Activation/valid forwarding to the east neighbour, one register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
        end
    end

    // Double-buffered weight: swap always moves the pre-edge shadow, so load+swap together is safe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            if (w_load) shadow_w <= w_in;
            if (w_swap) active_w <= shadow_w;
        end
    end

    // Multiplier: both forms are built, the parameter picks one; operands are widened before multiplying.
    always_comb begin
        a_sgn  = a_in;
        w_sgn  = active_w;
        prod_u = (2*DATA_W)'(a_in) * (2*DATA_W)'(active_w);
        prod_s = (2*DATA_W)'(a_sgn) * (2*DATA_W)'(w_sgn);
    end

    // Stage 1: operands and mode travel together so a mode change applies per sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_prod <= '0;
            s1_psum <= '0;
            s1_mode <= 1'b0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= a_vld_in;
            if (a_vld_in) begin
                s1_prod <= (SIGNED != 0) ? prod_s : prod_u;
                s1_psum <= psum_in;
                s1_mode <= mode;
            end
        end
    end

    // Stage-2 operands: product extended per signedness; acc_clr turns the accumulate into clear-and-load.
    always_comb begin
        s1_prod_sgn = s1_prod;
        prod_ext    = (SIGNED != 0) ? ACC_W'(s1_prod_sgn) : ACC_W'(s1_prod);
        if (s1_mode) addend = acc_clr ? '0 : acc;
        else         addend = s1_psum;
    end

`ifdef MAC_PE_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           sat_hit;

    // Saturating adder: carry-out for unsigned, same-sign-in/different-sign-out for two's complement.
    always_comb begin
        sum_wide = {1'b0, prod_ext} + {1'b0, addend};
        sum_res  = sum_wide[ACC_W-1:0];
        sat_hit  = 1'b0;
        if (SIGNED != 0) begin
            if ((prod_ext[ACC_W-1] == addend[ACC_W-1]) && (sum_wide[ACC_W-1] != addend[ACC_W-1])) begin
                sat_hit = 1'b1;
                sum_res = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (sum_wide[ACC_W]) begin
            sat_hit = 1'b1;
            sum_res = '1;
        end
    end

    // Sticky overflow: cleared by acc_clr, but a saturation on the same edge still sets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf <= 1'b0;
        else      ovf <= (ovf & ~acc_clr) | (s1_vld & sat_hit);
    end
`else
    assign sum_res = prod_ext + addend;
    assign ovf     = 1'b0;
`endif

    // Stage 2: result register, accumulator and output valid; idle cycles hold the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psum_out <= '0;
            psum_vld <= 1'b0;
            acc      <= '0;
        end else begin
            psum_vld <= s1_vld;
            if (s1_vld) psum_out <= sum_res;
            if (s1_vld && s1_mode) acc <= sum_res;
            else if (acc_clr)      acc <= '0;
        end
    end

endmodule
